// File: rtl/salaga_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Package     : salaga_pkg                                                 |
// | Description : Shared instruction-word constants and an address helper   |
// |               for the Salaga SoC fetch path.                             |
// | Revision    : 1.0                                                        |
// +--------------------------------------------------------------------------+
package salaga_pkg;

   localparam int               INST_W      = 32;
   localparam logic [INST_W-1:0] NOP_INST    = 32'h0000_0013;
   localparam logic [INST_W-1:0] EBREAK_INST = 32'h0010_0073;

   // Next sequential word address; wraps from 0xFFFF_FFFC to 0x0000_0000.
   function automatic logic [31:0] next_word_addr(input logic [31:0] addr);
      return {addr[31:2] + 30'd1, 2'b00};
   endfunction

endpackage
`default_nettype wire

// File: rtl/inst_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : inst_fifo                                                  |
// | Description : Small instruction FIFO with combinational head read.      |
// |               Flush empties it and has priority over push/pop.          |
// | Ports       : clk, reset (async, active low), flush, push, push_data,    |
// |               pop, head_data, count, full, empty                         |
// | Revision    : 1.0                                                        |
// +--------------------------------------------------------------------------+
module inst_fifo
   import salaga_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    flush,
   input  logic                    push,
   input  logic [INST_W-1:0]       push_data,
   input  logic                    pop,
   output logic [INST_W-1:0]       head_data,
   output logic [$clog2(DEPTH):0]  count,
   output logic                    full,
   output logic                    empty
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [INST_W-1:0] mem [DEPTH];
   logic [PTR_W-1:0]  rd_ptr;
   logic [PTR_W-1:0]  wr_ptr;
   logic              do_push;
   logic              do_pop;

   assign full  = (count == CNT_W'(DEPTH));
   assign empty = (count == '0);

   // A push into a full FIFO is accepted only when the head leaves in the
   // same cycle; the written slot is then the one being read this cycle.
   assign do_push = push && (!full || pop);
   assign do_pop  = pop && !empty;

   assign head_data = mem[rd_ptr];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Storage needs no reset: entries are only visible once counted.
   always_ff @(posedge clk) begin
      if (do_push && !flush) mem[wr_ptr] <= push_data;
   end

endmodule
`default_nettype wire

// File: rtl/inst_prefetch_buffer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : inst_prefetch_buffer                                       |
// | Description : Sequential instruction prefetcher between the processor    |
// |               fetch port and imem. Serves hits from a FIFO with zero     |
// |               latency; flushes and refetches on address discontinuity.  |
// | Ports       : clk, reset (async, active low)                             |
// |               ip_proc_inst_req / ip_proc_inst_addr   processor request   |
// |               op_proc_inst_valid / op_proc_inst      processor response  |
// |               op_imem_req / op_imem_inst_addr        imem fetch          |
// |               ip_imem_inst_valid / ip_imem_inst      imem return         |
// | Config      : PREFETCH_EBREAK_HOLD_EN - stop prefetching after an       |
// |               ebreak word is pushed, until the next redirect or reset.  |
// | Revision    : 1.0                                                        |
// +--------------------------------------------------------------------------+
module inst_prefetch_buffer
   import salaga_pkg::*;
#(
   parameter logic [31:0] RESET_PC_VALUE = 32'h0000_0000,
   parameter int          DEPTH          = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              ip_proc_inst_req,
   input  logic [31:0]       ip_proc_inst_addr,
   output logic              op_proc_inst_valid,
   output logic [INST_W-1:0] op_proc_inst,
   output logic              op_imem_req,
   output logic [31:0]       op_imem_inst_addr,
   input  logic              ip_imem_inst_valid,
   input  logic [INST_W-1:0] ip_imem_inst
);

   localparam logic [31:0] RESET_PC_ALIGNED = {RESET_PC_VALUE[31:2], 2'b00};

   logic [31:0]          head_addr;
   logic [31:0]          fetch_addr;
   logic                 halted;
   logic                 addr_match;
   logic                 hit;
   logic                 redirect;
   logic                 push;
   logic [INST_W-1:0]    fifo_head;
   logic [$clog2(DEPTH):0] fifo_count;
   logic                 fifo_full;
   logic                 fifo_empty;
   logic                 unused_count;

   assign unused_count = ^fifo_count;

   assign addr_match = (ip_proc_inst_addr[31:2] == head_addr[31:2]);
   assign hit        = ip_proc_inst_req && !fifo_empty && addr_match;
   assign redirect   = ip_proc_inst_req && !addr_match;

   // The reset input gates the request so that it is low for the whole time
   // reset is held, not only after the first edge. Masking with redirect is
   // what discards an imem return coinciding with a redirect.
   assign op_imem_req = reset && !halted && !redirect && (!fifo_full || hit);
   assign push        = op_imem_req && ip_imem_inst_valid;

   assign op_imem_inst_addr  = {fetch_addr[31:2], 2'b00};
   assign op_proc_inst_valid = hit;
   assign op_proc_inst       = hit ? fifo_head : NOP_INST;

   inst_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .flush     (redirect),
      .push      (push),
      .push_data (ip_imem_inst),
      .pop       (hit),
      .head_data (fifo_head),
      .count     (fifo_count),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         head_addr  <= RESET_PC_ALIGNED;
         fetch_addr <= RESET_PC_ALIGNED;
      end else if (redirect) begin
         head_addr  <= {ip_proc_inst_addr[31:2], 2'b00};
         fetch_addr <= {ip_proc_inst_addr[31:2], 2'b00};
      end else begin
         if (hit)  head_addr  <= next_word_addr(head_addr);
         if (push) fetch_addr <= next_word_addr(fetch_addr);
      end
   end

`ifdef PREFETCH_EBREAK_HOLD_EN
   // Redirect and push are mutually exclusive, so clearing on redirect can
   // never race with an ebreak being captured.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         halted <= 1'b0;
      end else if (redirect) begin
         halted <= 1'b0;
      end else if (push && (ip_imem_inst == EBREAK_INST)) begin
         halted <= 1'b1;
      end
   end
`else
   assign halted = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_inst_prefetch_buffer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_inst_prefetch_buffer                                    |
// | Description : Self-checking bench for inst_prefetch_buffer with a        |
// |               zero-wait/randomly-stalled imem and a queue-based model.  |
// | Revision    : 1.0                                                        |
// +--------------------------------------------------------------------------+
module tb_inst_prefetch_buffer;
   import salaga_pkg::*;

   localparam int          DEPTH = 4;
   localparam logic [31:0] RPC   = 32'h0000_0000;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        proc_req = 1'b0;
   logic [31:0] proc_addr = '0;
   logic        valid;
   logic [31:0] inst;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_rdy = 1'b0;
   logic [31:0] imem_inst;
   logic        ebreak_at_8 = 1'b0;

   always #5 clk = ~clk;

   inst_prefetch_buffer #(
      .RESET_PC_VALUE (RPC),
      .DEPTH          (DEPTH)
   ) dut (
      .clk                (clk),
      .reset              (reset),
      .ip_proc_inst_req   (proc_req),
      .ip_proc_inst_addr  (proc_addr),
      .op_proc_inst_valid (valid),
      .op_proc_inst       (inst),
      .op_imem_req        (imem_req),
      .op_imem_inst_addr  (imem_addr),
      .ip_imem_inst_valid (imem_rdy),
      .ip_imem_inst       (imem_inst)
   );

   // Memory contents: a simple hash of the address, optional ebreak at 0x8.
   function automatic logic [31:0] mem_word(input logic [31:0] a, input logic eb);
      if (eb && a[31:2] == 30'd2) return EBREAK_INST;
      return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
   endfunction

   assign imem_inst = mem_word(imem_addr, ebreak_at_8);

   // Reference model: queue of prefetched words plus the two addresses.
   logic [31:0] mq[$];
   logic [31:0] mh, mf;
   bit          mhalt;

   logic [65:0] exp_vec, obs_vec;
   bit          obs_valid, obs_req, obs_push;
   logic [31:0] obs_inst, obs_fetch;
   int          checks = 0;
   int          fails  = 0;

   task automatic model_init();
      mq.delete();
      mh    = {RPC[31:2], 2'b00};
      mf    = {RPC[31:2], 2'b00};
      mhalt = 1'b0;
   endtask

   // Drives one cycle (entered at posedge+1), samples outputs, advances model.
   task automatic cycle(input bit req, input logic [31:0] addr, input bit rdy);
      bit          hit, redir, ereq;
      logic [31:0] einst, w;
      proc_req  = req;
      proc_addr = addr;
      imem_rdy  = rdy;
      #3;
      redir = req && (addr[31:2] != mh[31:2]);
      hit   = req && !redir && (mq.size() != 0);
      ereq  = !mhalt && !redir && ((mq.size() < DEPTH) || hit);
      einst = hit ? mq[0] : NOP_INST;
      exp_vec   = {hit, einst, ereq, mf[31:2], 2'b00};
      obs_vec   = {valid, inst, imem_req, imem_addr};
      obs_valid = valid;
      obs_inst  = inst;
      obs_req   = imem_req;
      obs_push  = imem_req && rdy;
      obs_fetch = imem_addr;
      if (redir) begin
         mq.delete();
         mh    = {addr[31:2], 2'b00};
         mf    = {addr[31:2], 2'b00};
         mhalt = 1'b0;
      end else begin
         if (hit) begin
            void'(mq.pop_front());
            mh = mh + 32'd4;
         end
         if (ereq && rdy) begin
            w = mem_word(mf, ebreak_at_8);
            mq.push_back(w);
`ifdef PREFETCH_EBREAK_HOLD_EN
            if (w == EBREAK_INST) mhalt = 1'b1;
`endif
            mf = mf + 32'd4;
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset    = 1'b0;
      proc_req = 1'b0;
      imem_rdy = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      model_init();
      reset = 1'b1;
   endtask

   task automatic test_reset();
      reset     = 1'b0;
      proc_req  = 1'b1;
      proc_addr = RPC;
      imem_rdy  = 1'b1;
      repeat (2) @(posedge clk);
      #3;
      if (valid !== 1'b0) begin fails++; $display("FAIL rst_valid: got %b want 0", valid); end
      checks++;
      if (inst !== NOP_INST) begin fails++; $display("FAIL rst_inst: got %h want %h", inst, NOP_INST); end
      checks++;
      if (imem_req !== 1'b0) begin fails++; $display("FAIL rst_req: got %b want 0", imem_req); end
      checks++;
      if (imem_addr !== RPC) begin fails++; $display("FAIL rst_addr: got %h want %h", imem_addr, RPC); end
      checks++;
      @(posedge clk);
      #1;
      proc_req = 1'b0;
      model_init();
      reset = 1'b1;
      cycle(1'b0, RPC, 1'b1);
      if (obs_vec !== exp_vec) begin fails++; $display("FAIL rst_first: got %h want %h", obs_vec, exp_vec); end
      checks++;
   endtask

   task automatic test_sequential();
      do_reset();
      for (int i = 0; i < 20; i++) begin
         cycle(i != 0, RPC + 32'(4 * (i - 1)), 1'b1);
         if (obs_vec !== exp_vec) begin fails++; $display("FAIL seq cyc%0d: got %h want %h", i, obs_vec, exp_vec); end
         checks++;
         if (i != 0) begin
            if (!obs_valid || obs_inst !== mem_word(RPC + 32'(4 * (i - 1)), 1'b0)) begin
               fails++; $display("FAIL seq_hit cyc%0d: got v=%b %h want v=1", i, obs_valid, obs_inst);
            end
            checks++;
         end
      end
   endtask

   task automatic test_full();
      int pushes = 0;
      do_reset();
      for (int i = 0; i < 10; i++) begin
         cycle(1'b0, 32'h0, 1'b1);
         if (obs_push) pushes++;
         if (obs_vec !== exp_vec) begin fails++; $display("FAIL full cyc%0d: got %h want %h", i, obs_vec, exp_vec); end
         checks++;
      end
      if (pushes != DEPTH) begin fails++; $display("FAIL full_pushes: got %0d want %0d", pushes, DEPTH); end
      checks++;
      if (obs_req !== 1'b0) begin fails++; $display("FAIL full_req: got %b want 0", obs_req); end
      checks++;
      for (int i = 0; i < DEPTH; i++) begin
         cycle(1'b1, 32'(4 * i), 1'b0);
         if (obs_vec !== exp_vec || !obs_valid) begin
            fails++; $display("FAIL full_hit %0d: got %h want %h", i, obs_vec, exp_vec);
         end
         checks++;
      end
   endtask

   task automatic test_redirect();
      int waits = 0;
      do_reset();
      cycle(1'b0, 32'h0, 1'b1);
      for (int i = 0; i < 4; i++) cycle(1'b1, 32'(4 * i), 1'b1);
      for (int i = 0; i < 6; i++) cycle(1'b0, 32'h0, 1'b1);
      if (mh !== 32'h10 || mq.size() != DEPTH) begin
         fails++; $display("FAIL redir_setup: got head %h cnt %0d want 10/%0d", mh, mq.size(), DEPTH);
      end
      checks++;
      for (int i = 0; i < 6; i++) begin
         cycle(1'b1, 32'h40, 1'b1);
         if (obs_vec !== exp_vec) begin fails++; $display("FAIL redir cyc%0d: got %h want %h", i, obs_vec, exp_vec); end
         checks++;
         if (obs_valid) break;
         waits++;
      end
      if (waits != 2 || obs_inst !== mem_word(32'h40, 1'b0)) begin
         fails++; $display("FAIL redir_latency: got %0d waits inst %h want 2 waits inst %h",
                           waits, obs_inst, mem_word(32'h40, 1'b0));
      end
      checks++;
   endtask

   task automatic test_redirect_imem();
      cycle(1'b1, 32'h80, 1'b1);
      if (obs_vec !== exp_vec) begin fails++; $display("FAIL redir_imem: got %h want %h", obs_vec, exp_vec); end
      checks++;
      cycle(1'b1, 32'h80, 1'b0);
      if (obs_valid !== 1'b0 || obs_vec !== exp_vec) begin
         fails++; $display("FAIL redir_discard: got %h want %h", obs_vec, exp_vec);
      end
      checks++;
   endtask

   task automatic test_reset_midstream();
      do_reset();
      for (int i = 0; i < 3; i++) cycle(1'b0, 32'h0, 1'b1);
      proc_req  = 1'b1;
      proc_addr = RPC;
      imem_rdy  = 1'b1;
      #1;
      if (valid !== 1'b1 || inst !== mq[0]) begin
         fails++; $display("FAIL mid_pre: got v=%b %h want v=1 %h", valid, inst, mq[0]);
      end
      checks++;
      reset = 1'b0;
      #1;
      if ({valid, inst, imem_req, imem_addr} !== {1'b0, NOP_INST, 1'b0, RPC}) begin
         fails++; $display("FAIL mid_reset: got v=%b %h req=%b %h want 0 %h 0 %h",
                           valid, inst, imem_req, imem_addr, NOP_INST, RPC);
      end
      checks++;
      @(posedge clk);
      #1;
      model_init();
      reset = 1'b1;
      cycle(1'b1, RPC, 1'b1);
      if (obs_vec !== exp_vec || !obs_req || obs_fetch !== RPC) begin
         fails++; $display("FAIL mid_refetch: got %h want %h", obs_vec, exp_vec);
      end
      checks++;
   endtask

   task automatic test_wrap();
      int hits = 0;
      do_reset();
      cycle(1'b1, 32'hFFFF_FFF8, 1'b1);
      for (int i = 0; i < 8; i++) begin
         cycle(1'b1, mh, 1'b1);
         if (obs_valid) hits++;
         if (obs_vec !== exp_vec) begin fails++; $display("FAIL wrap cyc%0d: got %h want %h", i, obs_vec, exp_vec); end
         checks++;
      end
      if (hits != 7) begin fails++; $display("FAIL wrap_hits: got %0d want 7", hits); end
      checks++;
   endtask

   task automatic test_random();
      logic [31:0] a;
      bit          rq, rdy;
      do_reset();
      for (int i = 0; i < 500; i++) begin
         rq  = ($urandom_range(0, 99) < 85);
         rdy = ($urandom_range(0, 3) != 0);
         if ($urandom_range(0, 9) == 0) a = {22'd0, 8'($urandom_range(0, 255)), 2'($urandom_range(0, 3))};
         else                           a = mh | 32'($urandom_range(0, 3));
         cycle(rq, a, rdy);
         if (obs_vec !== exp_vec) begin fails++; $display("FAIL rand cyc%0d: got %h want %h", i, obs_vec, exp_vec); end
         checks++;
      end
   endtask

   task automatic test_ebreak();
      logic [31:0] max_req = '0;
      ebreak_at_8 = 1'b1;
      do_reset();
      for (int i = 0; i < 12; i++) begin
         cycle(1'b1, mh, 1'b1);
         if (obs_req && obs_fetch > max_req) max_req = obs_fetch;
         if (obs_vec !== exp_vec) begin fails++; $display("FAIL ebreak cyc%0d: got %h want %h", i, obs_vec, exp_vec); end
         checks++;
      end
`ifdef PREFETCH_EBREAK_HOLD_EN
      if (max_req !== 32'h8) begin fails++; $display("FAIL ebreak_hold: got max req %h want 8", max_req); end
`else
      if (max_req < 32'hC) begin fails++; $display("FAIL ebreak_nohold: got max req %h want >= c", max_req); end
`endif
      checks++;
      ebreak_at_8 = 1'b0;
   endtask

   initial begin
      test_reset();
      test_sequential();
      test_full();
      test_redirect();
      test_redirect_imem();
      test_reset_midstream();
      test_wrap();
      test_random();
      test_ebreak();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1);
   end

endmodule
`default_nettype wire
